// File: rtl/slew_dac_pkg.sv
// Shared definitions for the slew-limited DAC model.
//   state_t  : controller states (IDLE, RAMP_UP, RAMP_DOWN, DIP)
//   step_inc : maps the 4-bit step input to the per-cycle increment,
//              with a step of 0 treated as 1 so a ramp always makes progress.
package slew_dac_pkg;

  localparam int unsigned STEP_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    DIP       = 2'd3
  } state_t;

  function automatic logic [STEP_WIDTH-1:0] step_inc(input logic [STEP_WIDTH-1:0] step);
    return (step == '0) ? STEP_WIDTH'(1) : step;
  endfunction

endpackage

// File: rtl/slew_dac_timer.sv
// dip_timer: down-counter that sets the length of a dip.
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous active-high reset, clears the count
//   load    : start a new dip interval of CYCLES clock cycles
//   expired : high once the interval has run out (also high when idle)
// After a load, expired stays low for CYCLES-1 cycles, so a controller that
// leaves its dip state on the first edge that sees expired high spends
// exactly CYCLES cycles in that state.
module dip_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(CYCLES - 1);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/slew_dac.sv
// slew_dac: slew-rate limited DAC with an injectable temporary dip.
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous active-high reset
//   req     : request to load a new target (accepted only in IDLE)
//   target  : code to ramp to, latched when req is accepted
//   step    : code increment per cycle (0 behaves as 1)
//   dip_req : request a dip of DIP_CODE codes for DIP_CYCLES cycles
//   ack     : one-cycle pulse when req is accepted
//   busy    : high whenever the controller is not in IDLE
//   done    : one-cycle pulse when level first equals the target
//   level   : current nominal code, including any active dip
//   aout    : level scaled to volts, full scale code = VREF
module slew_dac
  import slew_dac_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter real         VREF       = 1.0,
  parameter int unsigned DIP_CODE   = 51,
  parameter int unsigned DIP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] target,
  input  logic [3:0]       step,
  input  logic             dip_req,
  output logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] level,
  output real              aout
);

  state_t           state, state_n;
  state_t           saved_state, saved_state_n;
  logic [WIDTH-1:0] tgt, tgt_n;
  logic [WIDTH-1:0] saved_level, saved_level_n;
  logic [WIDTH-1:0] level_n;
  logic             ack_n, done_n;
  logic             dip_load, dip_expired;

  // Ramp and dip arithmetic is carried one bit wider than the code so the
  // clamps below see true sums/differences instead of wrapped values.
  logic [WIDTH:0]   level_w, tgt_w, inc_w, dip_w, up_sum;
  logic [WIDTH-1:0] up_val, dn_val, dip_val;

  assign level_w = {1'b0, level};
  assign tgt_w   = {1'b0, tgt};
  assign inc_w   = (WIDTH+1)'(step_inc(step));
  assign dip_w   = (WIDTH+1)'(DIP_CODE);
  assign up_sum  = level_w + inc_w;

  assign up_val  = (up_sum >= tgt_w)          ? tgt : up_sum[WIDTH-1:0];
  assign dn_val  = (level_w <= tgt_w + inc_w) ? tgt : level - inc_w[WIDTH-1:0];
  assign dip_val = (level_w <= dip_w)         ? '0  : level - dip_w[WIDTH-1:0];

  dip_timer #(
    .CYCLES (DIP_CYCLES)
  ) u_dip_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (dip_load),
    .expired (dip_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      saved_state <= IDLE;
      tgt         <= '0;
      saved_level <= '0;
      level       <= '0;
      ack         <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      saved_state <= saved_state_n;
      tgt         <= tgt_n;
      saved_level <= saved_level_n;
      level       <= level_n;
      ack         <= ack_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n       = state;
    saved_state_n = saved_state;
    tgt_n         = tgt;
    saved_level_n = saved_level;
    level_n       = level;
    ack_n         = 1'b0;
    done_n        = 1'b0;
    dip_load      = 1'b0;

    // A dip pre-empts everything else in the cycle it arrives, including a
    // pending req in IDLE and the ramp step that would otherwise be taken.
    if (dip_req && (state != DIP)) begin
      saved_state_n = state;
      saved_level_n = level;
      level_n       = dip_val;
      state_n       = DIP;
      dip_load      = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            tgt_n = target;
            ack_n = 1'b1;
            if (target > level) begin
              state_n = RAMP_UP;
            end else if (target < level) begin
              state_n = RAMP_DOWN;
            end else begin
              done_n = 1'b1;
            end
          end
        end
        RAMP_UP: begin
          level_n = up_val;
          if (up_val == tgt) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        RAMP_DOWN: begin
          level_n = dn_val;
          if (dn_val == tgt) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        DIP: begin
          if (dip_expired) begin
            level_n = saved_level;
            state_n = saved_state;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign aout = real'(level) * VREF / (2.0 ** WIDTH - 1.0);

endmodule

// File: tb/tb_slew_dac.sv
// Directed self-checking bench for slew_dac at WIDTH=8, VREF=1.0,
// DIP_CODE=51, DIP_CYCLES=2. Inputs change 1 time unit after a rising edge
// and outputs are sampled at that same point.
module tb_slew_dac;

  logic       clk;
  logic       rst;
  logic       req;
  logic [7:0] target;
  logic [3:0] step;
  logic       dip_req;
  logic       ack;
  logic       busy;
  logic       done;
  logic [7:0] level;
  real        aout;

  int n_checks;
  int n_pass;

  slew_dac #(
    .WIDTH      (8),
    .VREF       (1.0),
    .DIP_CODE   (51),
    .DIP_CYCLES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .target  (target),
    .step    (step),
    .dip_req (dip_req),
    .ack     (ack),
    .busy    (busy),
    .done    (done),
    .level   (level),
    .aout    (aout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int milli(input real r);
    return $rtoi(r * 1000.0 + 0.5);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Step until done pulses, bounded so a stuck ramp cannot hang the run.
  task automatic run_to_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!done && n < max_cyc);
    chk(tag, int'(done), 1);
  endtask

  initial begin
    int exp_dn[7];
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    req      = 1'b0;
    target   = '0;
    step     = '0;
    dip_req  = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_level", int'(level), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_ack",   int'(ack), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_aout",  milli(aout), 0);
    rst = 1'b0;
    cyc();

    // Ramp up 0 -> 100 by 10
    req = 1'b1; target = 8'd100; step = 4'd10;
    cyc();
    req = 1'b0;
    chk("up_ack",   int'(ack), 1);
    chk("up_busy",  int'(busy), 1);
    chk("up_lvl0",  int'(level), 0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("up_lvl",  int'(level), 10 * i);
      chk("up_done", int'(done), (i == 10) ? 1 : 0);
      chk("up_ack0", int'(ack), 0);
    end
    chk("up_idle", int'(busy), 0);
    chk("up_aout", milli(aout), 392);
    cyc();
    chk("up_done_once", int'(done), 0);

    // Ramp down 100 -> 5 by 15, final step clamps at target
    exp_dn = '{85, 70, 55, 40, 25, 10, 5};
    req = 1'b1; target = 8'd5; step = 4'd15;
    cyc();
    req = 1'b0;
    chk("dn_ack", int'(ack), 1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("dn_lvl",  int'(level), exp_dn[i]);
      chk("dn_done", int'(done), (i == 6) ? 1 : 0);
    end
    cyc();
    chk("dn_hold", int'(level), 5);
    chk("dn_done_once", int'(done), 0);

    // Target equal to level: ack and done together, stay idle
    req = 1'b1; target = 8'd5; step = 4'd3;
    cyc();
    req = 1'b0;
    chk("eq_ack",  int'(ack), 1);
    chk("eq_done", int'(done), 1);
    chk("eq_busy", int'(busy), 0);

    // Down to 0 with a step larger than the level: no underflow
    cyc();
    req = 1'b1; target = 8'd0; step = 4'd15;
    cyc();
    req = 1'b0;
    chk("zero_ack", int'(ack), 1);
    cyc();
    chk("zero_lvl",  int'(level), 0);
    chk("zero_done", int'(done), 1);

    // step=0 behaves as 1; req during ramp is ignored
    req = 1'b1; target = 8'd3; step = 4'd0;
    cyc();
    chk("s0_ack", int'(ack), 1);
    req = 1'b0;
    cyc();
    chk("s0_lvl1", int'(level), 1);
    req = 1'b1; target = 8'd200;
    cyc();
    chk("s0_lvl2", int'(level), 2);
    chk("s0_noack", int'(ack), 0);
    cyc();
    chk("s0_lvl3",  int'(level), 3);
    chk("s0_done",  int'(done), 1);
    chk("s0_noack2", int'(ack), 0);
    req = 1'b0;
    cyc();
    chk("s0_hold", int'(level), 3);
    chk("s0_busy", int'(busy), 0);

    // Reset mid-ramp at level 40
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req = 1'b1; target = 8'd200; step = 4'd5;
    cyc();
    req = 1'b0;
    chk("mr_ack", int'(ack), 1);
    for (int i = 0; i < 8; i++) cyc();
    chk("mr_lvl40", int'(level), 40);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_lvl",  int'(level), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_done", int'(done), 0);
    cyc();
    chk("mr_done2", int'(done), 0);

    // Dip during RAMP_UP at level 50: saturates at 0, then resumes
    req = 1'b1; target = 8'd200; step = 4'd5;
    cyc();
    req = 1'b0;
    chk("rd_ack", int'(ack), 1);
    for (int i = 0; i < 10; i++) cyc();
    chk("rd_lvl50", int'(level), 50);
    dip_req = 1'b1;
    cyc();
    chk("rd_dip1", int'(level), 0);
    chk("rd_busy", int'(busy), 1);
    cyc();
    dip_req = 1'b0;
    chk("rd_dip2", int'(level), 0);
    cyc();
    chk("rd_restore", int'(level), 50);
    cyc();
    chk("rd_lvl55", int'(level), 55);
    cyc();
    chk("rd_lvl60", int'(level), 60);

    // Finish to 200, then down to 128 (last step clamps 140 -> 128)
    run_to_done("rd_finish", 40);
    chk("rd_lvl200", int'(level), 200);
    req = 1'b1; target = 8'd128; step = 4'd15;
    cyc();
    req = 1'b0;
    run_to_done("to128", 10);
    chk("lvl128", int'(level), 128);

    // Dip from IDLE with req in the same cycle: dip wins, no ack, no done
    req = 1'b1; target = 8'd10; dip_req = 1'b1;
    cyc();
    req = 1'b0; dip_req = 1'b0;
    chk("id_lvl77", int'(level), 77);
    chk("id_noack", int'(ack), 0);
    chk("id_aout77", milli(aout), 302);
    cyc();
    chk("id_lvl77b", int'(level), 77);
    chk("id_nodone", int'(done), 0);
    cyc();
    chk("id_restore", int'(level), 128);
    chk("id_aout128", milli(aout), 502);
    chk("id_busy", int'(busy), 0);
    chk("id_nodone2", int'(done), 0);
    cyc();
    chk("id_hold", int'(level), 128);
    chk("id_noack2", int'(ack), 0);

    // Ramp to full scale: last step clamps without wrapping
    req = 1'b1; target = 8'd255; step = 4'd15;
    cyc();
    req = 1'b0;
    run_to_done("fs_done", 20);
    chk("fs_lvl", int'(level), 255);
    chk("fs_aout", milli(aout), 1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/slew_dac.md
SLEW_DAC -- requirements
Module: slew_dac

Interface
REQ-001 Parameter WIDTH, default 8: code width of target and internal level.
REQ-002 Parameter VREF (real), default 1.0: analog value at full-scale code 2**WIDTH-1.
REQ-003 Parameter DIP_CODE, default 51: code depth of an injected dip (about 0.2 at VREF 1.0).
REQ-004 Parameter DIP_CYCLES, default 2: dip duration in clock cycles.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port req, input, 1: request to load a new target.
REQ-008 Port target, input, WIDTH: code to ramp to, sampled when the request is accepted.
REQ-009 Port step, input, 4: code increment per cycle; 0 is treated as 1.
REQ-010 Port dip_req, input, 1: request a temporary dip.
REQ-011 Port ack, output, 1: one-cycle pulse when req is accepted.
REQ-012 Port busy, output, 1: high while not in IDLE.
REQ-013 Port done, output, 1: one-cycle pulse when level first equals the target.
REQ-014 Port level, output, WIDTH: current nominal code, including any active dip.
REQ-015 Port aout, output, real: level * VREF / (2**WIDTH-1), combinational from level.

Function
REQ-016 The FSM SHALL have states IDLE, RAMP_UP, RAMP_DOWN and DIP.
- DIP returns to the saved state (RAMP_UP, RAMP_DOWN or IDLE).
REQ-017 In IDLE with req high, the block SHALL latch target, pulse ack next cycle and change state in that same cycle.
- target > level: go to RAMP_UP.
- target < level: go to RAMP_DOWN.
- target == level: stay IDLE and pulse done with ack.
REQ-018 req SHALL be ignored outside IDLE; no ack is given and the latched target is unchanged.
REQ-019 In RAMP_UP, each cycle level SHALL become min(level+step, target).
REQ-020 In RAMP_DOWN, each cycle level SHALL become max(level-step, target).
REQ-021 Ramp arithmetic SHALL use WIDTH+1 bits so there is no wrap-around at 0 or 2**WIDTH-1.
REQ-022 In the cycle level reaches the target, the block SHALL pulse done and return to IDLE.
- First change to aout is one cycle after ack.
REQ-023 When dip_req is high outside DIP, the block SHALL:
- save the current state;
- subtract DIP_CODE from level, saturating at 0;
- enter DIP for DIP_CYCLES cycles.
REQ-024 On DIP exit, level SHALL be restored to the pre-dip value and the saved state resumed; no ramp step is taken during DIP.
REQ-025 dip_req during DIP SHALL be ignored.
REQ-026 If req and dip_req arrive in the same IDLE cycle, the dip SHALL take priority and req SHALL stay unacknowledged until it is sampled again in IDLE.
REQ-027 done SHALL NOT pulse during DIP, even if the dipped level equals the target.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL set:
- state to IDLE;
- level to 0, so aout is 0.0;
- ack, done and busy to 0;
- the latched target and the dip counter to 0.
REQ-029 Reset in mid-ramp or mid-dip SHALL abandon the operation with no done pulse.

Structure
REQ-030 The state enum and the step-to-increment helper SHALL live in a shared package slew_dac_pkg.
REQ-031 The DIP_CYCLES down-counter SHALL be the sub-module dip_timer with ports clk, rst, load and expired.
REQ-032 The code-to-real conversion SHALL be a single continuous assignment with no state.

Verification
REQ-033 Reset, then req with target=100 and step=10 -> ack one cycle later; level runs 10, 20, ... 100 over 10 cycles; done on the cycle level=100; aout about 0.392.
REQ-034 From level=100, req with target=5 and step=15 -> level runs 85, 70, 55, 40, 25, 10, 5; done once; no underflow.
REQ-035 dip_req at level=50 during RAMP_UP (target 200, step 5) -> level=0 (saturated) for 2 cycles, then restores to 50 and continues 55, 60, ...
REQ-036 dip_req at IDLE with level=128 -> level 77 for 2 cycles, then 128; aout about 0.302, then about 0.502; no done pulse.
REQ-037 req with step=0 and target=3 from 0 -> level 1, 2, 3; done pulse; req raised again mid-ramp -> no ack.
REQ-038 rst asserted mid-ramp at level=40 -> next cycle level=0, busy=0, no done; a following req is accepted normally.
